// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port memory between fetch (F), data (D)
// and loader (L) requesters. Fixed priority D > F > L; an aging counter
// promotes L after MAX_WAIT lost rounds. Optional ARB_STATS_EN adds grant
// counters and a starvation-promotion pulse.
module mem_bus_arbiter #(
   parameter int unsigned AW       = 10,
   parameter int unsigned DW       = 16,
   parameter int unsigned MAX_WAIT = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          f_req,
   input  logic [AW-1:0] f_addr,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   input  logic          l_req,
   input  logic          l_we,
   input  logic [AW-1:0] l_addr,
   input  logic [DW-1:0] l_wdata,
   output logic          f_gnt,
   output logic          d_gnt,
   output logic          l_gnt,
   output logic          f_rvalid,
   output logic          d_rvalid,
   output logic          l_rvalid,
   output logic [DW-1:0] rdata,
`ifdef ARB_STATS_EN
   output logic [15:0]   f_cnt,
   output logic [15:0]   d_cnt,
   output logic [15:0]   l_cnt,
   output logic          starve_evt,
`endif
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   localparam int unsigned AGEW = 8;

   typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, RESP = 2'd2} state_t;
   typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_F = 2'd1, OWN_D = 2'd2, OWN_L = 2'd3} owner_t;

   state_t          state_q, state_d;
   owner_t          owner_q, owner_d;
   logic            we_q, we_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic [AGEW-1:0] age_q, age_d;
   logic [2:0]      gnt_q, gnt_d;
   logic [2:0]      rvalid_q, rvalid_d;
   logic            mem_en_q, mem_en_d;
   logic            mem_we_q, mem_we_d;
   logic            promote_c;

   // One-hot {L, D, F} strobe for a requester id
   function automatic logic [2:0] own_bit(input owner_t o);
      case (o)
         OWN_F:   return 3'b001;
         OWN_D:   return 3'b010;
         OWN_L:   return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   assign promote_c = l_req && (age_q == AGEW'(MAX_WAIT));

   // Next-state, latched request and output strobes
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      age_d    = age_q;
      gnt_d    = 3'b000;
      rvalid_d = 3'b000;
      mem_en_d = 1'b0;
      mem_we_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (!l_req) age_d = '0;
            if (promote_c) begin
               owner_d = OWN_L; we_d = l_we; addr_d = l_addr; wdata_d = l_wdata;
            end else if (d_req) begin
               owner_d = OWN_D; we_d = d_we; addr_d = d_addr; wdata_d = d_wdata;
            end else if (f_req) begin
               owner_d = OWN_F; we_d = 1'b0; addr_d = f_addr; wdata_d = '0;
            end else if (l_req) begin
               owner_d = OWN_L; we_d = l_we; addr_d = l_addr; wdata_d = l_wdata;
            end
            if (f_req || d_req || l_req) begin
               state_d  = ACC;
               gnt_d    = own_bit(owner_d);
               mem_en_d = 1'b1;
               mem_we_d = we_d;
               if (owner_d == OWN_L)
                  age_d = '0;
               else if (l_req && (age_q != AGEW'(MAX_WAIT)))
                  age_d = age_q + AGEW'(1);
            end
         end
         ACC: begin
            if (we_q) begin
               state_d = IDLE;
               owner_d = OWN_NONE;
            end else begin
               state_d  = RESP;
               rvalid_d = own_bit(owner_q);
            end
         end
         RESP: begin
            state_d = IDLE;
            owner_d = OWN_NONE;
            rdata_d = mem_rdata;
         end
         default: begin
            state_d = IDLE;
            owner_d = OWN_NONE;
         end
      endcase
   end

   // State and registered outputs; reset abandons any access in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         owner_q  <= OWN_NONE;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         age_q    <= '0;
         gnt_q    <= 3'b000;
         rvalid_q <= 3'b000;
         mem_en_q <= 1'b0;
         mem_we_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         age_q    <= age_d;
         gnt_q    <= gnt_d;
         rvalid_q <= rvalid_d;
         mem_en_q <= mem_en_d;
         mem_we_q <= mem_we_d;
      end
   end

`ifdef ARB_STATS_EN
   // Per-requester grant counters and promoted-grant pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         f_cnt      <= '0;
         d_cnt      <= '0;
         l_cnt      <= '0;
         starve_evt <= 1'b0;
      end else begin
         f_cnt      <= f_cnt + 16'(gnt_q[0]);
         d_cnt      <= d_cnt + 16'(gnt_q[1]);
         l_cnt      <= l_cnt + 16'(gnt_q[2]);
         starve_evt <= (state_q == IDLE) && promote_c;
      end
   end
`endif

   assign f_gnt     = gnt_q[0];
   assign d_gnt     = gnt_q[1];
   assign l_gnt     = gnt_q[2];
   assign f_rvalid  = rvalid_q[0];
   assign d_rvalid  = rvalid_q[1];
   assign l_rvalid  = rvalid_q[2];
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   // Read data passes straight through during RESP, otherwise holds the last return
   assign rdata     = (state_q == RESP) ? mem_rdata : rdata_q;
   assign busy      = (state_q != IDLE);

endmodule
